// File: rtl/sm_gpio_irq.sv
// GPIO edge-capture interrupt stage: sticky rise/fall pending bits, mask, and a
// registered level irq, all reached over the simple peripheral bus.
module sm_gpio_irq #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bSel,
   input  logic [31:0]       bAddr,
   input  logic              bWrite,
   input  logic [31:0]       bWData,
   output logic [31:0]       bRData,
   input  logic [WIDTH-1:0]  gpioIn,
   output logic              irq
);

   localparam logic [4:0] A_PEND = 5'h00;
   localparam logic [4:0] A_MASK = 5'h04;
   localparam logic [4:0] A_RISE = 5'h08;
   localparam logic [4:0] A_FALL = 5'h0C;
   localparam logic [4:0] A_RAW  = 5'h10;

   logic [WIDTH-1:0] r_pending;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_rise_en;
   logic [WIDTH-1:0] r_fall_en;
   logic [WIDTH-1:0] r_prev;
   logic             r_primed;
   logic             r_irq;

   logic             w_wr;
   logic             w_wr_pend;
   logic             w_wr_mask;
   logic             w_wr_rise;
   logic             w_wr_fall;
   logic [WIDTH-1:0] w_wdata;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic             w_unused_bits;

   function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
      logic [31:0] z;
      z          = 32'd0;
      z[WIDTH-1:0] = v;
      return z;
   endfunction

   assign w_wr          = bSel & bWrite;
   assign w_wr_pend     = w_wr & (bAddr[4:0] == A_PEND);
   assign w_wr_mask     = w_wr & (bAddr[4:0] == A_MASK);
   assign w_wr_rise     = w_wr & (bAddr[4:0] == A_RISE);
   assign w_wr_fall     = w_wr & (bAddr[4:0] == A_FALL);
   assign w_wdata       = bWData[WIDTH-1:0];
   assign w_unused_bits = ^{bAddr, bWData};

   // Edge events and write-1-to-clear vector; nothing is detected until primed
   always_comb begin
      w_clr  = {WIDTH{1'b0}};
      w_rise = {WIDTH{1'b0}};
      w_fall = {WIDTH{1'b0}};
      if (w_wr_pend) begin
         w_clr = w_wdata;
      end else begin
         w_clr = {WIDTH{1'b0}};
      end
      if (r_primed) begin
         w_rise = gpioIn & ~r_prev & r_rise_en;
         w_fall = ~gpioIn & r_prev & r_fall_en;
      end else begin
         w_rise = {WIDTH{1'b0}};
         w_fall = {WIDTH{1'b0}};
      end
   end

   // State registers; a new event on a bit overrides its simultaneous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= {WIDTH{1'b0}};
         r_mask    <= {WIDTH{1'b0}};
         r_rise_en <= {WIDTH{1'b0}};
         r_fall_en <= {WIDTH{1'b0}};
         r_prev    <= {WIDTH{1'b0}};
         r_primed  <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_prev    <= gpioIn;
         r_primed  <= 1'b1;
         r_pending <= (r_pending & ~w_clr) | w_rise | w_fall;
         r_irq     <= |(r_pending & r_mask);
         if (w_wr_mask) r_mask    <= w_wdata;
         if (w_wr_rise) r_rise_en <= w_wdata;
         if (w_wr_fall) r_fall_en <= w_wdata;
      end
   end

   // Read mux, independent of bSel
   always_comb begin
      bRData = 32'd0;
      case (bAddr[4:0])
         A_PEND:  bRData = zext(r_pending);
         A_MASK:  bRData = zext(r_mask);
         A_RISE:  bRData = zext(r_rise_en);
         A_FALL:  bRData = zext(r_fall_en);
         A_RAW:   bRData = zext(gpioIn);
         default: bRData = 32'd0;
      endcase
   end

   assign irq = r_irq;

endmodule

// File: tb/tb_sm_gpio_irq.sv
// Bench for sm_gpio_irq: directed vector table, reset corner sequence and
// randomized traffic checked against a per-pin behavioural model.
module tb_sm_gpio_irq;

   logic        clk;
   logic        rst_n;
   logic        bSel;
   logic [31:0] bAddr;
   logic        bWrite;
   logic [31:0] bWData;
   logic [31:0] bRData;
   logic [7:0]  gpioIn;
   logic        irq;

   int n_chk = 0;
   int n_err = 0;

   sm_gpio_irq #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .bSel(bSel), .bAddr(bAddr), .bWrite(bWrite),
      .bWData(bWData), .bRData(bRData), .gpioIn(gpioIn), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: what software would believe the block holds
   bit [7:0] m_pend, m_mask, m_rise, m_fall, m_last;
   bit       m_seen_edge, m_irq;

   function automatic void m_reset();
      m_pend = 8'h00; m_mask = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
      m_last = 8'h00; m_seen_edge = 1'b0; m_irq = 1'b0;
   endfunction

   function automatic void m_edge(input bit sel, input bit [31:0] addr, input bit wr,
                                  input bit [31:0] wd, input bit [7:0] g);
      bit [7:0] np;
      bit       wen;
      wen   = sel && wr;
      m_irq = (m_pend & m_mask) != 8'h00;
      np    = m_pend;
      for (int i = 0; i < 8; i++) begin
         bit went_up, went_down, event_seen, cleared;
         went_up    = m_seen_edge && g[i] && !m_last[i];
         went_down  = m_seen_edge && !g[i] && m_last[i];
         event_seen = (went_up && m_rise[i]) || (went_down && m_fall[i]);
         cleared    = wen && (addr[4:0] == 5'h00) && wd[i];
         if (event_seen)   np[i] = 1'b1;
         else if (cleared) np[i] = 1'b0;
      end
      m_pend = np;
      if (wen && addr[4:0] == 5'h04) m_mask = wd[7:0];
      if (wen && addr[4:0] == 5'h08) m_rise = wd[7:0];
      if (wen && addr[4:0] == 5'h0C) m_fall = wd[7:0];
      m_last      = g;
      m_seen_edge = 1'b1;
   endfunction

   function automatic bit [31:0] m_read(input bit [4:0] a);
      case (a)
         5'h00:   return {24'd0, m_pend};
         5'h04:   return {24'd0, m_mask};
         5'h08:   return {24'd0, m_rise};
         5'h0C:   return {24'd0, m_fall};
         5'h10:   return {24'd0, gpioIn};
         default: return 32'd0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bAddr = a;
      #1;
      d = bRData;
   endtask

   // One bus/pin cycle: drive, take the clock edge, advance the model
   task automatic cyc(input logic sel, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [7:0] g);
      bSel = sel; bAddr = addr; bWrite = wr; bWData = wd; gpioIn = g;
      @(posedge clk);
      m_edge(sel, addr, wr, wd, g);
      #1;
      bSel = 1'b0; bWrite = 1'b0;
   endtask

   task automatic check_model(input string tag);
      logic [31:0] d;
      logic [31:0] regs [5];
      regs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10};
      foreach (regs[i]) begin
         rd(regs[i], d);
         chk($sformatf("%s_reg%0h", tag, regs[i]), d, m_read(regs[i][4:0]));
      end
      chk({tag, "_irq"}, {31'd0, irq}, {31'd0, m_irq});
   endtask

   typedef struct {
      logic        sel;
      logic [4:0]  addr;
      logic        wr;
      logic [7:0]  wd;
      logic [7:0]  g;
      logic [7:0]  exp_pend;
      logic        exp_irq;
   } vec_t;

   vec_t vt [29];

   initial begin
      logic [31:0] d;
      logic [7:0]  g;

      vt[0]  = '{1'b1, 5'h08, 1'b1, 8'hFF, 8'h05, 8'h00, 1'b0};
      vt[1]  = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h05, 8'h00, 1'b0};
      vt[2]  = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h05, 8'h00, 1'b0};
      vt[3]  = '{1'b0, 5'h00, 1'b1, 8'hFF, 8'h05, 8'h00, 1'b0};
      vt[4]  = '{1'b1, 5'h08, 1'b1, 8'h01, 8'h04, 8'h00, 1'b0};
      vt[5]  = '{1'b1, 5'h04, 1'b1, 8'h01, 8'h04, 8'h00, 1'b0};
      vt[6]  = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h05, 8'h01, 1'b0};
      vt[7]  = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h05, 8'h01, 1'b1};
      vt[8]  = '{1'b1, 5'h0C, 1'b1, 8'h80, 8'h85, 8'h01, 1'b1};
      vt[9]  = '{1'b1, 5'h04, 1'b1, 8'h00, 8'h85, 8'h01, 1'b1};
      vt[10] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h05, 8'h81, 1'b0};
      vt[11] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h05, 8'h81, 1'b0};
      vt[12] = '{1'b1, 5'h04, 1'b1, 8'h80, 8'h05, 8'h81, 1'b0};
      vt[13] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h05, 8'h81, 1'b1};
      vt[14] = '{1'b1, 5'h00, 1'b1, 8'hFF, 8'h05, 8'h00, 1'b1};
      vt[15] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h05, 8'h00, 1'b0};
      vt[16] = '{1'b1, 5'h08, 1'b1, 8'h03, 8'h05, 8'h00, 1'b0};
      vt[17] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h04, 8'h00, 1'b0};
      vt[18] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h07, 8'h03, 1'b0};
      vt[19] = '{1'b1, 5'h00, 1'b1, 8'h01, 8'h07, 8'h02, 1'b0};
      vt[20] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h05, 8'h02, 1'b0};
      vt[21] = '{1'b1, 5'h00, 1'b1, 8'h02, 8'h07, 8'h02, 1'b0};
      vt[22] = '{1'b1, 5'h14, 1'b1, 8'hFF, 8'h07, 8'h02, 1'b0};
      vt[23] = '{1'b1, 5'h08, 1'b1, 8'h04, 8'h03, 8'h02, 1'b0};
      vt[24] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h07, 8'h06, 1'b0};
      vt[25] = '{1'b1, 5'h04, 1'b1, 8'h04, 8'h03, 8'h06, 1'b0};
      vt[26] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h07, 8'h06, 1'b1};
      vt[27] = '{1'b1, 5'h00, 1'b1, 8'h06, 8'h07, 8'h00, 1'b1};
      vt[28] = '{1'b0, 5'h00, 1'b0, 8'h00, 8'h07, 8'h00, 1'b0};

      rst_n = 1'b0; bSel = 1'b0; bAddr = 32'd0; bWrite = 1'b0; bWData = 32'd0;
      gpioIn = 8'h05;
      m_reset();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      check_model("reset");

      for (int i = 0; i < 29; i++) begin
         cyc(vt[i].sel, {27'h5A5A5A0, vt[i].addr}, vt[i].wr, {24'hABCDEF, vt[i].wd}, vt[i].g);
         rd(32'h0, d);
         chk($sformatf("vec%0d_pend", i), d, {24'd0, vt[i].exp_pend});
         chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
      end
      rd(32'h10, d);
      chk("raw_read", d, 32'h00000007);
      check_model("after_table");

      // Async reset between clock edges with irq high
      cyc(1'b1, 32'h08, 1'b1, 32'h01, 8'h00);
      cyc(1'b1, 32'h04, 1'b1, 32'h01, 8'h00);
      cyc(1'b0, 32'h00, 1'b0, 32'h00, 8'h01);
      cyc(1'b0, 32'h00, 1'b0, 32'h00, 8'h01);
      chk("pre_rst_irq", {31'd0, irq}, 32'd1);
      #2 rst_n = 1'b0;
      m_reset();
      #1;
      chk("async_rst_irq", {31'd0, irq}, 32'd0);
      rd(32'h00, d); chk("async_rst_pend", d, 32'd0);
      rd(32'h04, d); chk("async_rst_mask", d, 32'd0);
      rd(32'h14, d); chk("unmapped_14", d, 32'd0);
      rd(32'h18, d); chk("unmapped_18", d, 32'd0);
      #1 rst_n = 1'b1;

      // Randomized traffic against the model
      g = 8'h01;
      for (int n = 0; n < 400; n++) begin
         logic [4:0]  a;
         logic [31:0] offs [7];
         offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C};
         a = offs[$urandom_range(0, 6)][4:0];
         if ($urandom_range(0, 2) == 0) g = g ^ 8'($urandom);
         cyc(1'($urandom), {27'($urandom), a}, 1'($urandom), $urandom, g);
         rd(32'h00, d);
         chk($sformatf("rnd%0d_pend", n), d, m_read(5'h00));
         chk($sformatf("rnd%0d_irq", n), {31'd0, irq}, {31'd0, m_irq});
         if (n % 50 == 49) check_model($sformatf("rnd%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
